game_timer: RTL and testbench

Parametrised second/tick timer for the crane-game display path. It divides the system clock down to a configurable tick rate and drives a count that can run up or down, with start/stop, pause, load and clear controls. It raises terminal-count, expiry and low-time warning indications, and its count feeds the seven-segment display logic and the game control FSM (round timer, countdown to claw drop).

---
 rtl/game_timer.sv | 132 +++++++++++++
 tb/tb_game_timer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: prescaled up/down tick counter with start/stop/pause, load,
// clear, terminal-count detection, sticky expiry and low-time warning.
module game_timer #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TICK_HZ    = 1,
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned UP_LIMIT   = 2**WIDTH - 1,
   parameter int unsigned WARN_LEVEL = 10
) (
   input  logic             clock_100Mhz,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             down,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tick,
   output logic             done,
   output logic             expired,
   output logic             warn
);

   localparam int unsigned      DIV        = CLK_HZ / TICK_HZ;
   localparam int unsigned      PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] LIMIT      = WIDTH'(UP_LIMIT);
   localparam logic [WIDTH-1:0] LIMIT_M1   = WIDTH'(UP_LIMIT - 1);
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic [PW-1:0]    r_presc;
   logic             r_running;
   logic             r_tick;
   logic             r_done;
   logic             r_expired;

   logic [WIDTH-1:0] w_count_nxt;
   logic [PW-1:0]    w_presc_nxt;
   logic             w_running_nxt;
   logic             w_tick_nxt;
   logic             w_done_nxt;
   logic             w_expired_nxt;

   logic             w_term_now;
   logic             w_term_next;
   logic             w_tick_due;

   // Count already sits at the terminal value for the current direction
   assign w_term_now  = down ? (r_count == '0) : (r_count >= LIMIT);
   // The upcoming tick lands on the terminal value
   assign w_term_next = down ? (r_count == ONE) : (r_count == LIMIT_M1);
   assign w_tick_due  = r_running & (r_presc == PRESC_LAST);

   // Next-state: control pulses in priority order, then prescaler/tick
   always_comb begin
      w_count_nxt   = r_count;
      w_presc_nxt   = r_presc;
      w_running_nxt = r_running;
      w_expired_nxt = r_expired;
      w_tick_nxt    = 1'b0;
      w_done_nxt    = 1'b0;

      if (clear) begin
         w_count_nxt   = '0;
         w_presc_nxt   = '0;
         w_running_nxt = 1'b0;
         w_expired_nxt = 1'b0;
      end else if (load) begin
         w_count_nxt   = load_value;
         w_presc_nxt   = '0;
         w_running_nxt = 1'b0;
         w_expired_nxt = 1'b0;
      end else if (stop) begin
         // prescaler holds so resume keeps the sub-tick phase
         w_running_nxt = 1'b0;
      end else begin
         if (start && !r_running && !w_term_now) begin
            w_running_nxt = 1'b1;
         end
         if (r_running) begin
            if (w_tick_due) begin
               w_presc_nxt = '0;
               if (w_term_now) begin
                  // direction flipped onto a terminal value: halt, never wrap
                  w_running_nxt = 1'b0;
               end else begin
                  w_tick_nxt  = 1'b1;
                  w_count_nxt = down ? (r_count - ONE) : (r_count + ONE);
                  if (w_term_next) begin
                     w_done_nxt    = 1'b1;
                     w_expired_nxt = 1'b1;
                     w_running_nxt = 1'b0;
                  end
               end
            end else begin
               w_presc_nxt = r_presc + PW'(1);
            end
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clock_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_count   <= '0;
         r_presc   <= '0;
         r_running <= 1'b0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_expired <= 1'b0;
      end else begin
         r_count   <= w_count_nxt;
         r_presc   <= w_presc_nxt;
         r_running <= w_running_nxt;
         r_tick    <= w_tick_nxt;
         r_done    <= w_done_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   assign count   = r_count;
   assign running = r_running;
   assign tick    = r_tick;
   assign done    = r_done;
   assign expired = r_expired;
   assign warn    = r_running & down & (r_count != '0) &
                    (32'(r_count) <= WARN_LEVEL);

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with DIV=10, WIDTH=8, UP_LIMIT=5, WARN_LEVEL=2.
module tb_game_timer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, clear, load, down;
   logic [7:0] load_value;
   logic [7:0] count;
   logic       running, tick, done, expired, warn;

   int n_checks = 0;
   int n_errors = 0;

   game_timer #(
      .CLK_HZ    (10),
      .TICK_HZ   (1),
      .WIDTH     (8),
      .UP_LIMIT  (5),
      .WARN_LEVEL(2)
   ) dut (
      .clock_100Mhz(clk),
      .reset_n     (rst_n),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .load        (load),
      .load_value  (load_value),
      .down        (down),
      .count       (count),
      .running     (running),
      .tick        (tick),
      .done        (done),
      .expired     (expired),
      .warn        (warn)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 ns past the edge
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse one or more control inputs for a single sampling edge
   task automatic pulse(input logic s, input logic p, input logic c, input logic l);
      start = s; stop = p; clear = c; load = l;
      cyc(1);
      start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
      down = 1'b0; load_value = 8'd0;
      cyc(2);

      // reset state
      chk("rst_count",   32'(count),   32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_tick",    32'(tick),    32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_expired", 32'(expired), 32'd0);
      chk("rst_warn",    32'(warn),    32'd0);
      rst_n = 1'b1;
      cyc(1);

      // up-count to UP_LIMIT=5
      pulse(1, 0, 0, 0);
      chk("up_running", 32'(running), 32'd1);
      cyc(9);
      chk("up_pre_first", 32'(count), 32'd0);
      cyc(1);
      chk("up_c1",      32'(count), 32'd1);
      chk("up_c1_tick", 32'(tick),  32'd1);
      cyc(1);
      chk("up_tick_pulse", 32'(tick), 32'd0);
      cyc(9);
      chk("up_c2", 32'(count), 32'd2);
      cyc(30);
      chk("up_c5",         32'(count),   32'd5);
      chk("up_c5_tick",    32'(tick),    32'd1);
      chk("up_c5_done",    32'(done),    32'd1);
      chk("up_c5_expired", 32'(expired), 32'd1);
      chk("up_c5_running", 32'(running), 32'd0);
      chk("up_warn",       32'(warn),    32'd0);
      cyc(50);
      chk("up_hold_count", 32'(count),   32'd5);
      chk("up_hold_done",  32'(done),    32'd0);
      chk("up_hold_exp",   32'(expired), 32'd1);

      // down-count from 3 with warn
      down = 1'b1; load_value = 8'd3;
      pulse(0, 0, 0, 1);
      chk("ld_count",   32'(count),   32'd3);
      chk("ld_expired", 32'(expired), 32'd0);
      chk("ld_running", 32'(running), 32'd0);
      pulse(1, 0, 0, 0);
      chk("dn_running", 32'(running), 32'd1);
      chk("dn_warn3",   32'(warn),    32'd0);
      cyc(10);
      chk("dn_c2",    32'(count), 32'd2);
      chk("dn_warn2", 32'(warn),  32'd1);
      cyc(10);
      chk("dn_c1",    32'(count), 32'd1);
      chk("dn_warn1", 32'(warn),  32'd1);
      cyc(10);
      chk("dn_c0",      32'(count),   32'd0);
      chk("dn_done",    32'(done),    32'd1);
      chk("dn_tick",    32'(tick),    32'd1);
      chk("dn_warn0",   32'(warn),    32'd0);
      chk("dn_expired", 32'(expired), 32'd1);
      pulse(1, 0, 0, 0);
      chk("dn_start_ignored", 32'(running), 32'd0);
      chk("dn_count_hold",    32'(count),   32'd0);

      // pause/resume keeps prescaler phase
      down = 1'b0;
      pulse(0, 0, 1, 0);
      chk("clr_expired", 32'(expired), 32'd0);
      pulse(1, 0, 0, 0);
      cyc(10);
      chk("pr_c1", 32'(count), 32'd1);
      cyc(4);                         // prescaler now 4
      pulse(0, 1, 0, 0);
      chk("pr_stopped", 32'(running), 32'd0);
      cyc(50);
      chk("pr_idle_count", 32'(count), 32'd1);
      pulse(1, 0, 0, 0);              // resume edge
      cyc(5);
      chk("pr_before", 32'(count), 32'd1);
      cyc(1);
      chk("pr_c2",      32'(count), 32'd2);
      chk("pr_c2_tick", 32'(tick),  32'd1);
      pulse(0, 1, 0, 0);

      // clear + load + start together: clear wins
      load_value = 8'd7;
      start = 1'b1; clear = 1'b1; load = 1'b1;
      cyc(1);
      start = 1'b0; clear = 1'b0; load = 1'b0;
      chk("clr_win_count",   32'(count),   32'd0);
      chk("clr_win_running", 32'(running), 32'd0);

      // load + start with a tick due: load wins, tick discarded
      pulse(1, 0, 0, 0);
      cyc(9);                         // prescaler at 9, tick due next edge
      load_value = 8'd4;
      pulse(1, 0, 0, 1);
      chk("ld_win_count",   32'(count),   32'd4);
      chk("ld_win_running", 32'(running), 32'd0);
      chk("ld_win_tick",    32'(tick),    32'd0);

      // stop coincident with tick: count unchanged
      pulse(1, 0, 0, 0);
      cyc(9);
      pulse(0, 1, 0, 0);
      chk("stop_tick_count",   32'(count),   32'd4);
      chk("stop_tick_running", 32'(running), 32'd0);
      chk("stop_tick_tick",    32'(tick),    32'd0);

      // start while running with tick due: tick proceeds, reaches limit
      start = 1'b1;
      cyc(1);
      chk("st_run", 32'(running), 32'd1);
      cyc(1);
      start = 1'b0;
      chk("st_tick_count", 32'(count),   32'd5);
      chk("st_tick_done",  32'(done),    32'd1);
      chk("st_tick_run",   32'(running), 32'd0);
      pulse(1, 0, 0, 0);
      chk("up_term_start_ignored", 32'(running), 32'd0);

      // out-of-range load in up mode: start ignored
      load_value = 8'd9;
      pulse(0, 0, 0, 1);
      pulse(1, 0, 0, 0);
      chk("ovr_count",   32'(count),   32'd9);
      chk("ovr_running", 32'(running), 32'd0);

      // asynchronous reset mid-count
      pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      cyc(37);                        // count 3, prescaler 7
      chk("mr_pre_count", 32'(count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_count",   32'(count),   32'd0);
      chk("mr_running", 32'(running), 32'd0);
      chk("mr_tick",    32'(tick),    32'd0);
      chk("mr_expired", 32'(expired), 32'd0);
      #3;
      rst_n = 1'b1;
      cyc(1);
      pulse(1, 0, 0, 0);
      cyc(9);
      chk("mr_pre_first", 32'(count), 32'd0);
      cyc(1);
      chk("mr_first", 32'(count), 32'd1);
      pulse(0, 0, 1, 0);

      // mode flip from up to down while running
      pulse(1, 0, 0, 0);
      cyc(30);
      chk("mf_c3", 32'(count), 32'd3);
      down = 1'b1;
      cyc(10);
      chk("mf_c2",   32'(count), 32'd2);
      chk("mf_warn", 32'(warn),  32'd1);
      cyc(10);
      chk("mf_c1", 32'(count), 32'd1);
      cyc(10);
      chk("mf_c0",      32'(count),   32'd0);
      chk("mf_done",    32'(done),    32'd1);
      chk("mf_expired", 32'(expired), 32'd1);
      chk("mf_running", 32'(running), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Safety bound on total runtime
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
